ps2_scan_decoder: RTL and testbench

- Front end of the keyboard input path. Receives raw PS/2 clock and data lines from the keyboard.
- Deframes the serial bytes and strips set-2 break (F0) and extended (E0) prefixes.
- Emits one-cycle make-code strobes (code + valid). These feed the coordinate and action decoders as their scan-code/enable inputs.
- Break codes and keyboard protocol bytes never reach downstream.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_sync_edge.sv | 48 ++++
 rtl/ps2_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix and key codes, protocol bytes, frame FSM states.
// Imported by the scan decoder and by the downstream coordinate and action decoders.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_Q     = 8'h15;

  localparam int unsigned PS2_NUM_PROTO = 7;
  localparam logic [7:0] PS2_PROTO_BYTES [PS2_NUM_PROTO] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Keyboard self-test, echo, ack, error and resend bytes are never key codes.
  function automatic logic is_protocol_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_PROTO; i++) begin
      if (b == PS2_PROTO_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 clock and data lines and flags each ps2_clk falling edge,
// capturing the data line in the same cycle the edge is reported.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_bit
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic clk_hist_q, clk_hist_d;
  logic fall_q, fall_d;
  logic data_q, data_d;

  // Idle lines are high, so everything resets to 1 to avoid a phantom edge.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_hist_d  = clk_sync_q[SYNC_STAGES-1];
    fall_d      = clk_hist_q & ~clk_sync_q[SYNC_STAGES-1];
    data_d      = fall_d ? data_sync_q[SYNC_STAGES-1] : data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_hist_q  <= 1'b1;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_hist_q  <= clk_hist_d;
      fall_q      <= fall_d;
      data_q      <= data_d;
    end
  end

  assign clk_fall = fall_q;
  assign data_bit = data_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 front end: deframes keyboard bytes, strips E0/F0 prefixes and emits
// one-cycle make-code strobes; break codes and protocol bytes are swallowed.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       extended,
  output logic       valid,
  output logic       frame_err
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic fall, data_bit, timeout;

  ps2_state_e state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_ok_q, parity_ok_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         code_q, code_d;
  logic               ext_q, ext_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               ext_flag_q, ext_flag_d;
  logic               brk_flag_q, brk_flag_d;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_fall (fall),
    .data_bit (data_bit)
  );

  // A stalled keyboard clock mid-frame abandons the partial byte.
  assign timeout = (state_q != IDLE) && !fall &&
                   (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!data_bit) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    timer_d     = (state_q == IDLE || fall) ? '0 : timer_q + TIMER_W'(1);
    code_d      = code_q;
    ext_d       = ext_q;
    valid_d     = 1'b0;
    frame_err_d = timeout;
    ext_flag_d  = ext_flag_q;
    brk_flag_d  = brk_flag_q;
    if (fall) begin
      unique case (state_q)
        IDLE:   bit_cnt_d = 3'd0;
        DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: parity_ok_d = ^{shift_q, data_bit};
        STOP: begin
          if (data_bit && parity_ok_q) begin
            if (shift_q == PS2_EXT) begin
              ext_flag_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_flag_d = 1'b1;
            end else begin
              ext_flag_d = 1'b0;
              brk_flag_d = 1'b0;
              if (!is_protocol_byte(shift_q) && !brk_flag_q) begin
                code_d  = shift_q;
                ext_d   = ext_flag_q;
                valid_d = 1'b1;
              end
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_ok_q <= 1'b0;
      timer_q     <= '0;
      code_q      <= 8'd0;
      ext_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ext_flag_q  <= 1'b0;
      brk_flag_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      timer_q     <= timer_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      ext_flag_q  <= ext_flag_d;
      brk_flag_q  <= brk_flag_d;
    end
  end

  assign code      = code_q;
  assign extended  = ext_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: drives PS/2 frames, queues expected make
// codes and matches them against each valid strobe.
module tb_ps2_scan_decoder;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] code;
  logic       extended;
  logic       valid;
  logic       frameErr;

  logic [8:0] expQ[$];
  int vectors = 0;
  int miscompares = 0;
  int errSeen = 0;
  int errExp = 0;

  ps2_scan_decoder #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2Clk),
    .ps2_data  (ps2Data),
    .code      (code),
    .extended  (extended),
    .valid     (valid),
    .frame_err (frameErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    ps2Data = b;
    waitCycles(4);
    ps2Clk = 1'b0;
    waitCycles(HALF);
    ps2Clk = 1'b1;
    waitCycles(HALF);
  endtask

  // One full frame; expectations are queued before the first bit goes out.
  task automatic applyStimulus(input logic [7:0] b, input logic flipParity,
                               input logic stopBit, input logic expValid,
                               input logic expExt, input logic expErr);
    if (expValid) expQ.push_back({expExt, b});
    if (expErr) errExp++;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~^b ^ flipParity);
    sendBit(stopBit);
    ps2Data = 1'b1;
    waitCycles(30);
  endtask

  task automatic checkpoint(input string tag);
    checkOutput({tag, ".pending"}, expQ.size(), 0);
    checkOutput({tag, ".frameErrs"}, errSeen, errExp);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (valid) begin
        checkOutput("strobeOverlap", {31'd0, frameErr}, 0);
        if (expQ.size() == 0) begin
          checkOutput("spuriousValid", {31'd0, valid}, 0);
        end else begin
          logic [8:0] e;
          e = expQ.pop_front();
          checkOutput("code", {24'd0, code}, {24'd0, e[7:0]});
          checkOutput("extended", {31'd0, extended}, {31'd0, e[8]});
        end
      end
      if (frameErr) errSeen++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    waitCycles(3);
    checkOutput("resetCode", {24'd0, code}, 0);
    checkOutput("resetExtended", {31'd0, extended}, 0);
    checkOutput("resetValid", {31'd0, valid}, 0);
    checkOutput("resetFrameErr", {31'd0, frameErr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    waitCycles(10);

    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkpoint("plain");

    applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkpoint("extPrefix");
    applyStimulus(8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkpoint("extMake");

    applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h74, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkpoint("breaks");
    applyStimulus(8'hFA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkpoint("afterBreaks");

    applyStimulus(8'h15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkpoint("parityErr");
    applyStimulus(8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkpoint("stopErr");
    checkOutput("codeHold", {24'd0, code}, 32'h5A);
    checkOutput("extHold", {31'd0, extended}, 0);

    errExp++;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    waitCycles(TIMEOUT + 10);
    checkpoint("timeout");
    applyStimulus(8'h72, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkpoint("afterTimeout");

    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b0);
    @(negedge clk);
    resetn = 1'b0;
    waitCycles(2);
    checkOutput("midResetCode", {24'd0, code}, 0);
    checkOutput("midResetExtended", {31'd0, extended}, 0);
    checkOutput("midResetValid", {31'd0, valid}, 0);
    checkOutput("midResetFrameErr", {31'd0, frameErr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    waitCycles(20);
    applyStimulus(8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkpoint("afterReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
